conv_pool_ctrl: RTL and testbench
=================================

# conv_pool_ctrl

Block-sequencing and write-back controller for the convolution + 2×2 max-pool engine. It issues one block request per 4×4 image block for a programmed frame length, tracks in-flight blocks with credits, and buffers the engine's three 8-bit channel results. Those results drain through a single shared output-memory write port, one channel per cycle. It sits between the host/top-level sequencer (start/done) and the engine's request and result ports.

## Interface
- FIFO_DEPTH, 4: result buffer entries (power of two, ≥2); also the credit limit for outstanding blocks.
- ADDR_W, 16: block address width.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start pulse; sampled only in IDLE.
- num_blks  in  ADDR_W+1  frame length in blocks, 0..65536; latched on accepted start.
- busy  out  1  high from the cycle after accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at frame completion.
- blk_re  out  1  block request to engine, one cycle per block.
- blk_addr  out  ADDR_W  block index, 0..num_blks-1 in order.
- res_vld  in  1  engine result valid.
- res_addr  in  ADDR_W  block index of the result.
- res_y0, res_y1, res_y2  in  8 each  channel 0/1/2 pooled results.
- wr_en  out  1  shared output memory write enable.
- wr_addr  out  ADDR_W+2  {channel[1:0], block index}.
- wr_data  out  8  channel result byte.
- err  out  1  sticky overflow flag; cleared only by rst.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start; latches num_blks; clears the issue counter.
  - RUN → DONE when all four hold: issued == num_blks, inflight == 0, FIFO empty, and no drain in progress.
  - DONE → IDLE unconditionally after one cycle.
- Issue rule in RUN: blk_re=1 when issued < num_blks and (inflight + fifo_count) < FIFO_DEPTH. At most one request per cycle. blk_addr = issued[ADDR_W-1:0]; issued increments on each request.
- inflight: +1 on blk_re, −1 on res_vld, net 0 when both occur in the same cycle. It is never negative; a res_vld with inflight == 0 sets err and the result is dropped.
- FIFO push: on res_vld, push {res_addr, y0, y1, y2}. A push when full sets err and the result is dropped; this is unreachable under the credit rule.
- Drain:
  - A 2-bit channel counter steps 0→1→2 while the FIFO is non-empty.
  - Each step drives wr_en=1, wr_addr={ch, head.addr}, wr_data=head.y[ch].
  - Pop on ch==2; the counter returns to 0.
  - Push and pop in the same cycle are both allowed.
- The controller does not assume a fixed engine latency; ordering and credits alone guarantee correctness.
- start while busy is ignored. res_vld in IDLE sets err.
- num_blks == 0: no requests; DONE one cycle after entering RUN.
- Counters are ADDR_W+1 bits; issued == 65536 is representable, so there is no wrap.

## Timing
- Reset values: busy=0, done=0, blk_re=0, blk_addr=0, wr_en=0, wr_addr=0, wr_data=0, err=0. FSM=IDLE, FIFO empty, counters 0.
- All outputs are registered.
- The start pulse is accepted at edge T. busy=1 and the first blk_re=1 in cycle T+1.
- A result arriving at edge R is written into the FIFO at R and appears on wr_en in cycle R+1.
- Each block occupies 3 write cycles. Sustained throughput is 1 block per 3 cycles; issue self-throttles through credits.
- done and busy are both high in the DONE cycle; busy=0 the following cycle.
- rst mid-frame: all state clears on the next edge. Late res_vld from the engine after reset sets err (the engine is expected to be reset together with this block).

## Configuration
- CONV_POOL_CTRL_PERF_EN defined:
  - Adds outputs perf_cycles (32-bit, counts cycles in RUN) and perf_stalls (32-bit, counts RUN cycles with issued < num_blks and no credit).
  - Both counters clear on accepted start and on rst, and hold after DONE.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package conv_pool_pkg:
  - ctrl_state_t enum (IDLE, RUN, DONE).
  - res_entry_t packed struct {addr, y0, y1, y2}.
  - Localparams NUM_CH=3 and MAX_BLKS=65536.
- One sub-module, conv_pool_res_fifo: synchronous FIFO of res_entry_t, parameterised depth, with full/empty/count outputs. FSM, credits and drain live in the top.

## Test plan
- num_blks=1, engine model with 3-cycle latency, y=(0x11,0x22,0x33) → one blk_re at addr 0. Writes {0,0}=0x11, {1,0}=0x22, {2,0}=0x33 on consecutive cycles, then a done pulse, err=0.
- num_blks=8, 3-cycle model → blk_addr 0..7 in order. 24 writes cycling ch 0,1,2 per block, in ascending block order. done once.
- Engine delays results by 20 cycles, FIFO_DEPTH=4 → never more than 4 blk_re outstanding; all 16 blocks written correctly. With PERF_EN, perf_stalls > 0.
- num_blks=0 → no blk_re and no wr_en; done exactly 2 cycles after the start edge.
- start pulsed again mid-frame → ignored, frame completes with the original count. Then rst asserted mid-second-frame → all outputs 0 on the next cycle, FSM idle.
- Spurious res_vld in IDLE → err=1 and stays 1 until rst; no wr_en is generated.

Source files
------------

// File: rtl/conv_pool_pkg.sv
// Shared types and constants for the convolution + max-pool sequencing controller.
// Contents: ctrl_state_t FSM encoding, res_entry_t result payload (block index plus
// three pooled channel bytes), width constants and a channel-select helper.
package conv_pool_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned MAX_BLKS = 65536;
  // Frame-length and issue counters hold MAX_BLKS itself, so one bit wider than ADDR_W.
  localparam int unsigned CNT_W    = $clog2(MAX_BLKS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y2;
  } res_entry_t;

  // Select one channel byte of a buffered result.
  function automatic logic [DATA_W-1:0] chan_byte(input res_entry_t e, input logic [1:0] ch);
    case (ch)
      2'd0:    return e.y0;
      2'd1:    return e.y1;
      default: return e.y2;
    endcase
  endfunction

endpackage

// File: rtl/conv_pool_ctrl_if.sv
// Host/engine/output-memory bundle of the conv_pool_ctrl block.
// slave  : the controller (drives busy, done, blk_re/blk_addr, wr_*, err).
// master : the surrounding system (drives start/num_blks and engine results).
// With CONV_POOL_CTRL_PERF_EN defined the bundle also carries perf_cycles/perf_stalls.
interface conv_pool_ctrl_if;
  import conv_pool_pkg::*;

  logic                start;
  logic [CNT_W-1:0]    num_blks;
  logic                busy;
  logic                done;
  logic                blk_re;
  logic [ADDR_W-1:0]   blk_addr;
  logic                res_vld;
  logic [ADDR_W-1:0]   res_addr;
  logic [DATA_W-1:0]   res_y0;
  logic [DATA_W-1:0]   res_y1;
  logic [DATA_W-1:0]   res_y2;
  logic                wr_en;
  logic [ADDR_W+1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                err;
`ifdef CONV_POOL_CTRL_PERF_EN
  logic [31:0]         perf_cycles;
  logic [31:0]         perf_stalls;
`endif

  modport slave (
    input  start, num_blks, res_vld, res_addr, res_y0, res_y1, res_y2,
    output busy, done, blk_re, blk_addr, wr_en, wr_addr, wr_data, err
`ifdef CONV_POOL_CTRL_PERF_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport master (
    output start, num_blks, res_vld, res_addr, res_y0, res_y1, res_y2,
    input  busy, done, blk_re, blk_addr, wr_en, wr_addr, wr_data, err
`ifdef CONV_POOL_CTRL_PERF_EN
    , input perf_cycles, perf_stalls
`endif
  );

endinterface

// File: rtl/conv_pool_res_fifo.sv
// Synchronous result FIFO of res_entry_t entries, first-word fall-through head.
// Ports: clk, rst (sync, active-high), i_push/i_data, i_pop, o_head_c (current head),
// o_full_c, o_empty_c, o_count (registered occupancy). Push when full and pop when
// empty are ignored; the caller is expected to gate them.
module conv_pool_res_fifo
  import conv_pool_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned FCNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  res_entry_t        i_data,
  input  logic              i_pop,
  output res_entry_t        o_head_c,
  output logic              o_full_c,
  output logic              o_empty_c,
  output logic [FCNT_W-1:0] o_count
);

  res_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full_c  = (r_count == FCNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full_c;
  assign w_pop     = i_pop && !o_empty_c;

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_pool_ctrl.sv
// Block-sequencing and write-back controller for the conv + 2x2 max-pool engine.
// Issues one block request per block of the programmed frame, limits outstanding
// blocks with credits (in-flight + buffered <= FIFO_DEPTH), buffers engine results
// and drains them one channel byte per cycle through a shared write port.
// Ports: clk, rst (sync, active-high), bus (conv_pool_ctrl_if.slave):
//   start/num_blks/busy/done : frame control; blk_re/blk_addr : engine requests;
//   res_vld/res_addr/res_y0..2 : engine results; wr_en/wr_addr/wr_data : output memory;
//   err : sticky overflow / unexpected-result flag.
// Optional: CONV_POOL_CTRL_PERF_EN adds perf_cycles and perf_stalls counters.
module conv_pool_ctrl
  import conv_pool_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  conv_pool_ctrl_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned CRED_W  = FCNT_W + 1;
  localparam logic [1:0]  LAST_CH = 2'(NUM_CH - 1);

  ctrl_state_t        r_state;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_issued;
  logic [FCNT_W-1:0]  r_inflight;
  logic [1:0]         r_ch;
  logic               r_busy;
  logic               r_done;
  logic               r_blk_re;
  logic [ADDR_W-1:0]  r_blk_addr;
  logic               r_wr_en;
  logic [ADDR_W+1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_err;

  res_entry_t         w_in;
  res_entry_t         w_head;
  res_entry_t         w_src;
  logic               w_full;
  logic               w_empty;
  logic [FCNT_W-1:0]  w_count;
  logic               w_res_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_step;
  logic               w_more;
  logic               w_credit;
  logic               w_issue;
  logic               w_finish;
  logic [CNT_W-1:0]   w_issued_base;

  assign w_in = {bus.res_addr, bus.res_y0, bus.res_y1, bus.res_y2};

  conv_pool_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_in),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // A result is only legitimate while a request is outstanding (never in IDLE).
  assign w_res_ok = bus.res_vld && (r_inflight != '0);
  assign w_push   = w_res_ok && !w_full;

  assign w_more   = (r_issued < r_num);
  assign w_credit = (CRED_W'(r_inflight) + CRED_W'(w_count)) < CRED_W'(FIFO_DEPTH);

  // The first request goes out on the start edge so blk_re rises with busy.
  assign w_issued_base = (r_state == IDLE) ? '0 : r_issued;
  assign w_issue = (r_state == IDLE) ? (bus.start && (bus.num_blks != '0))
                                     : ((r_state == RUN) && w_more && w_credit);

  // An empty FIFO is bypassed by the arriving result so channel 0 writes next cycle;
  // the entry is still pushed to supply channels 1 and 2.
  assign w_step = !w_empty || w_push;
  assign w_src  = w_empty ? w_in : w_head;
  assign w_pop  = w_step && (r_ch == LAST_CH);

  assign w_finish = (r_state == RUN) && !w_more && (r_inflight == '0) && w_empty && (r_ch == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_issued   <= '0;
      r_inflight <= '0;
      r_ch       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_blk_re   <= 1'b0;
      r_blk_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_blk_re <= w_issue;
      r_issued <= w_issued_base + CNT_W'(w_issue);
      if (w_issue) r_blk_addr <= w_issued_base[ADDR_W-1:0];

      case ({w_issue, w_res_ok})
        2'b10:   r_inflight <= r_inflight + FCNT_W'(1);
        2'b01:   r_inflight <= r_inflight - FCNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (bus.res_vld && !w_push) r_err <= 1'b1;

      r_wr_en <= w_step;
      if (w_step) begin
        r_wr_addr <= {r_ch, w_src.addr};
        r_wr_data <= chan_byte(w_src, r_ch);
        r_ch      <= w_pop ? 2'd0 : r_ch + 2'd1;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_num   <= bus.num_blks;
          end
        end
        RUN: begin
          if (w_finish) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CONV_POOL_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  // Frame statistics: RUN cycles, and RUN cycles where work remained but no credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (r_state == RUN) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_more && !w_credit) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stalls = r_perf_stalls;
`endif

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.blk_re   = r_blk_re;
  assign bus.blk_addr = r_blk_addr;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_conv_pool_ctrl.sv
// Directed bench for conv_pool_ctrl: in-order engine model with programmable latency,
// output monitor logging requests/writes/done, one task per scenario.
module tb_conv_pool_ctrl;
  import conv_pool_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_pool_ctrl_if bus();
  conv_pool_ctrl #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stimulus bytes for a block: channel ch of block a is a + 0x11*(ch+1).
  function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] a, input int ch);
    return 8'(a) + 8'(17 * (ch + 1));
  endfunction

  // Engine model: in order, result no earlier than eng_lat cycles after the request.
  int                eng_lat  = 3;
  logic              spur_req = 1'b0;
  int                max_pend = 0;
  logic [ADDR_W-1:0] pend_a[$];
  int unsigned       pend_t[$];
  int unsigned       res_cyc[$];

  initial begin
    logic [ADDR_W-1:0] a;
    bus.res_vld  = 1'b0;
    bus.res_addr = '0;
    bus.res_y0   = '0;
    bus.res_y1   = '0;
    bus.res_y2   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        pend_a.delete();
        pend_t.delete();
        bus.res_vld = 1'b0;
      end else begin
        if (bus.blk_re) begin
          pend_a.push_back(bus.blk_addr);
          pend_t.push_back(cyc + eng_lat);
        end
        if (pend_a.size() > max_pend) max_pend = pend_a.size();
        if (spur_req) begin
          a = 16'h0055;
          bus.res_vld = 1'b1;
          bus.res_addr = a;
          bus.res_y0 = exp_byte(a, 0);
          bus.res_y1 = exp_byte(a, 1);
          bus.res_y2 = exp_byte(a, 2);
        end else if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
          a = pend_a.pop_front();
          void'(pend_t.pop_front());
          bus.res_vld = 1'b1;
          bus.res_addr = a;
          bus.res_y0 = exp_byte(a, 0);
          bus.res_y1 = exp_byte(a, 1);
          bus.res_y2 = exp_byte(a, 2);
          res_cyc.push_back(cyc);
        end else begin
          bus.res_vld = 1'b0;
        end
      end
    end
  end

  // Output monitor.
  logic [ADDR_W+1:0] wa_q[$];
  logic [7:0]        wd_q[$];
  int unsigned       wc_q[$];
  logic [ADDR_W-1:0] ba_q[$];
  int unsigned       dc_q[$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (bus.blk_re) ba_q.push_back(bus.blk_addr);
    if (bus.done) dc_q.push_back(cyc);
  end

  task automatic start_frame(input int n, output int unsigned s);
    @(negedge clk);
    bus.num_blks = CNT_W'(n);
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    for (int i = 0; i < 3000 && dc_q.size() <= base; i++) @(negedge clk);
    checks++;
    if (dc_q.size() <= base) begin
      errors++;
      $display("FAIL %s_done_timeout: done pulses=%0d required=1", name, dc_q.size() - base);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.blk_re, bus.blk_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b blk_re=%b blk_addr=%h wr_en=%b wr_addr=%h wr_data=%h err=%b required all 0",
               bus.busy, bus.done, bus.blk_re, bus.blk_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned s;
    int wb = wa_q.size(), bb = ba_q.size(), db = dc_q.size(), rb = res_cyc.size();
    eng_lat = 3;
    start_frame(1, s);
    checks++;
    if ({bus.busy, bus.blk_re, bus.blk_addr} !== {2'b11, 16'h0000}) begin
      errors++;
      $display("FAIL single_first_req: busy=%b blk_re=%b blk_addr=%h required 1 1 0000", bus.busy, bus.blk_re, bus.blk_addr);
    end
    wait_done(db, "single");
    checks++;
    if (ba_q.size() - bb !== 1) begin
      errors++;
      $display("FAIL single_req_count: got %0d required 1", ba_q.size() - bb);
    end
    checks++;
    if (wa_q.size() - wb !== 3 || res_cyc.size() - rb < 1) begin
      errors++;
      $display("FAIL single_write_count: got %0d required 3", wa_q.size() - wb);
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        checks++;
        if (wa_q[wb+ch] !== {2'(ch), 16'h0000} || wd_q[wb+ch] !== 8'(17 * (ch + 1)) ||
            wc_q[wb+ch] !== res_cyc[rb] + 1 + ch) begin
          errors++;
          $display("FAIL single_write%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   ch, wa_q[wb+ch], wd_q[wb+ch], wc_q[wb+ch], {2'(ch), 16'h0000}, 8'(17 * (ch + 1)), res_cyc[rb] + 1 + ch);
        end
      end
      checks++;
      if (dc_q.size() - db !== 1 || dc_q[db] <= wc_q[wb+2]) begin
        errors++;
        $display("FAIL single_done: pulses=%0d required 1 after last write", dc_q.size() - db);
      end
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL single_err: got %b required 0", bus.err);
    end
  endtask

  // Frame of n blocks; checks request order and the full write stream.
  task automatic run_and_check(input int n, input int lat, input string name);
    int unsigned s;
    int wb = wa_q.size(), bb = ba_q.size(), db = dc_q.size();
    logic [ADDR_W-1:0] blk;
    eng_lat = lat;
    start_frame(n, s);
    wait_done(db, name);
    checks++;
    if (ba_q.size() - bb !== n) begin
      errors++;
      $display("FAIL %s_req_count: got %0d required %0d", name, ba_q.size() - bb, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (ba_q[bb+i] !== 16'(i)) begin
          errors++;
          $display("FAIL %s_req_addr%0d: got %h required %h", name, i, ba_q[bb+i], 16'(i));
        end
      end
    end
    checks++;
    if (wa_q.size() - wb !== 3 * n) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wa_q.size() - wb, 3 * n);
    end else begin
      for (int i = 0; i < 3 * n; i++) begin
        blk = 16'(i / 3);
        checks++;
        if (wa_q[wb+i] !== {2'(i % 3), blk} || wd_q[wb+i] !== exp_byte(blk, i % 3)) begin
          errors++;
          $display("FAIL %s_write%0d: addr=%h data=%h required addr=%h data=%h",
                   name, i, wa_q[wb+i], wd_q[wb+i], {2'(i % 3), blk}, exp_byte(blk, i % 3));
        end
      end
    end
    checks++;
    if (dc_q.size() - db !== 1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_err: done pulses=%0d err=%b required 1 and 0", name, dc_q.size() - db, bus.err);
    end
  endtask

  task automatic test_multi();
    run_and_check(8, 3, "multi");
  endtask

  task automatic test_backpressure();
    run_and_check(16, 20, "bp");
    checks++;
    if (max_pend !== 4) begin
      errors++;
      $display("FAIL bp_outstanding: max outstanding=%0d required 4", max_pend);
    end
`ifdef CONV_POOL_CTRL_PERF_EN
    checks++;
    if (bus.perf_stalls == 0 || bus.perf_cycles == 0) begin
      errors++;
      $display("FAIL bp_perf: cycles=%0d stalls=%0d required both nonzero", bus.perf_cycles, bus.perf_stalls);
    end
`endif
  endtask

  task automatic test_zero();
    int unsigned s;
    int wb = wa_q.size(), bb = ba_q.size(), db = dc_q.size();
    start_frame(0, s);
    checks++;
    if ({bus.busy, bus.blk_re, bus.done} !== 3'b100) begin
      errors++;
      $display("FAIL zero_run: busy=%b blk_re=%b done=%b required 1 0 0", bus.busy, bus.blk_re, bus.done);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b11 || cyc !== s + 2) begin
      errors++;
      $display("FAIL zero_done: busy=%b done=%b at cyc %0d required 1 1 at %0d", bus.busy, bus.done, cyc, s + 2);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL zero_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ba_q.size() != bb || wa_q.size() != wb || dc_q.size() - db !== 1) begin
      errors++;
      $display("FAIL zero_activity: reqs=%0d writes=%0d dones=%0d required 0 0 1",
               ba_q.size() - bb, wa_q.size() - wb, dc_q.size() - db);
    end
  endtask

  task automatic test_restart();
    int unsigned s;
    int wb = wa_q.size(), bb = ba_q.size(), db = dc_q.size();
    eng_lat = 3;
    start_frame(6, s);
    repeat (3) @(negedge clk);
    bus.num_blks = CNT_W'(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(db, "restart");
    checks++;
    if (ba_q.size() - bb !== 6 || wa_q.size() - wb !== 18 || dc_q.size() - db !== 1) begin
      errors++;
      $display("FAIL restart_ignored: reqs=%0d writes=%0d dones=%0d required 6 18 1",
               ba_q.size() - bb, wa_q.size() - wb, dc_q.size() - db);
    end
    start_frame(8, s);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.blk_re, bus.blk_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b blk_re=%b blk_addr=%h wr_en=%b wr_addr=%h wr_data=%h err=%b required all 0",
               bus.busy, bus.blk_re, bus.blk_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.busy, bus.blk_re, bus.wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_idle: busy=%b blk_re=%b wr_en=%b required 0 0 0", bus.busy, bus.blk_re, bus.wr_en);
    end
    run_and_check(2, 3, "postreset");
  endtask

  task automatic test_spurious();
    int wb = wa_q.size();
    @(negedge clk);
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_err: got %b required 1", bus.err);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || wa_q.size() != wb || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_sticky: err=%b writes=%0d busy=%b required 1 0 0", bus.err, wa_q.size() - wb, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL spurious_clear: err=%b required 0", bus.err);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_blks = '0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero();
    test_restart();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
